// File: rtl/pipe_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_engine_if
// Description : Bundle between the pipe engine and its surroundings. The
//               controller side (master) drives the scroll strobe, the
//               start/pause pulses and the bird position. The engine side
//               (slave) returns the flattened pipe positions, score, speed,
//               collision flag and game state.
// Ports       : tick, start, pause, birdY            master -> slave
//               pipeX_flat, pipeY_flat, score_count,
//               speed, collision, game_state         slave  -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_engine_if #(
  parameter int NUM_PIPES = 4
);
  logic                      tick;
  logic                      start;
  logic                      pause;
  logic [31:0]               birdY;
  logic [32*NUM_PIPES-1:0]   pipeX_flat;
  logic [32*NUM_PIPES-1:0]   pipeY_flat;
  logic [31:0]               score_count;
  logic [2:0]                speed;
  logic                      collision;
  logic [1:0]                game_state;

  modport master (
    output tick, start, pause, birdY,
    input  pipeX_flat, pipeY_flat, score_count, speed, collision, game_state
  );

  modport slave (
    input  tick, start, pause, birdY,
    output pipeX_flat, pipeY_flat, score_count, speed, collision, game_state
  );
endinterface
`default_nettype wire

// File: rtl/pipe_engine.sv
`default_nettype none
// ============================================================================
// Module      : pipe_engine
// Description : Obstacle and game-flow engine. Keeps NUM_PIPES pipes in a
//               recycling ring, draws fresh gap heights from a 16-bit LFSR,
//               counts pipes passed, detects bird/pipe/floor overlap and runs
//               the IDLE/RUN/PAUSED/DEAD state machine.
//               Optional feature macro: DIFFICULTY_RAMP_EN - speed rises by
//               one px/tick every RAMP_STEP scored pipes, up to MAX_SPEED.
//               Without it the speed is a constant 1.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - pipe_engine_if slave (tick/start/pause/birdY in;
//                      pipe buses, score, speed, collision, state out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_engine #(
  parameter int NUM_PIPES   = 4,
  parameter int PIPE_SEP    = 250,
  parameter int PIPE_W      = 78,
  parameter int PIPE_GAP    = 75,
  parameter int SCREEN_W    = 640,
  parameter int FLOOR_Y     = 400,
  parameter int Y_MIN       = 60,
  parameter int Y_MASK      = 127,
  parameter int BIRD_X      = 150,
  parameter int BIRD_SIZE_X = 54,
  parameter int BIRD_SIZE_Y = 45,
  parameter int RAMP_STEP   = 10,
  parameter int MAX_SPEED   = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_engine_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  // Geometry as 33-bit signed so pipes left of the screen compare correctly.
  localparam logic signed [32:0] c_pipe_w   = 33'(PIPE_W);
  localparam logic signed [32:0] c_pipe_gap = 33'(PIPE_GAP);
  localparam logic signed [32:0] c_floor_y  = 33'(FLOOR_Y);
  localparam logic signed [32:0] c_bird_x   = 33'(BIRD_X);
  localparam logic signed [32:0] c_bird_x_r = 33'(BIRD_X + BIRD_SIZE_X);
  localparam logic signed [32:0] c_bird_sy  = 33'(BIRD_SIZE_Y);
  localparam logic signed [32:0] c_ring     = 33'(NUM_PIPES * PIPE_SEP);
  localparam logic [31:0]        c_y_reset  = 32'(Y_MIN + (Y_MASK >> 1));
  localparam logic [15:0]        c_lfsr_seed = 16'hACE1;

  state_t             r_state, w_state_nx;
  logic signed [31:0] r_pipe_x [NUM_PIPES];
  logic [31:0]        r_pipe_y [NUM_PIPES];
  logic [31:0]        r_score;
  logic [2:0]         r_speed;
  logic               r_collision;
  logic [15:0]        r_lfsr;

  logic [31:0]        w_x_nx [NUM_PIPES];
  logic [NUM_PIPES-1:0] w_wrap, w_cross, w_pipe_hit;
  logic [31:0]        w_cross_cnt;
  logic [32:0]        w_score_sum;
  logic [31:0]        w_y_spawn;
  logic signed [32:0] w_bird_top, w_bird_bot;
  logic               w_hit_any, w_hit, w_reload, w_scroll, w_set_coll, w_clr_coll;

  assign w_bird_top = $signed({1'b0, bus.birdY});
  assign w_bird_bot = w_bird_top + c_bird_sy;
  // Every pipe recycling on the same tick samples this one value.
  assign w_y_spawn  = 32'(Y_MIN) + ({16'b0, r_lfsr} & 32'(Y_MASK));

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    logic signed [32:0] px, py, x_dec, x_wrap;
    assign px     = {r_pipe_x[i][31], r_pipe_x[i]};
    assign py     = $signed({1'b0, r_pipe_y[i]});
    assign x_dec  = px - $signed({30'b0, r_speed});
    assign x_wrap = x_dec + c_ring;
    assign w_wrap[i]  = (x_dec <= -c_pipe_w);
    assign w_x_nx[i]  = w_wrap[i] ? x_wrap[31:0] : x_dec[31:0];
    // Scoring uses the pre-recycle position: right edge crosses the bird's left.
    assign w_cross[i] = (px + c_pipe_w >= c_bird_x) && (x_dec + c_pipe_w < c_bird_x);
    assign w_pipe_hit[i] = (px < c_bird_x_r) && (px + c_pipe_w > c_bird_x) &&
                           ((w_bird_top < py) || (w_bird_bot > py + c_pipe_gap));
    assign bus.pipeX_flat[32*i +: 32] = r_pipe_x[i];
    assign bus.pipeY_flat[32*i +: 32] = r_pipe_y[i];
  end

  always_comb begin
    w_cross_cnt = '0;
    w_hit_any   = (w_bird_bot > c_floor_y);
    for (int i = 0; i < NUM_PIPES; i++) begin
      w_cross_cnt = w_cross_cnt + 32'(w_cross[i]);
      w_hit_any   = w_hit_any | w_pipe_hit[i];
    end
  end

  assign w_hit       = (r_state == S_RUN) && w_hit_any;
  assign w_score_sum = {1'b0, r_score} + {1'b0, w_cross_cnt};

  // Hit outranks pause, and pause outranks tick, while running.
  always_comb begin
    w_state_nx = r_state;
    w_reload   = 1'b0;
    w_scroll   = 1'b0;
    w_set_coll = 1'b0;
    w_clr_coll = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.start) begin w_state_nx = S_RUN; w_reload = 1'b1; end
      S_RUN: begin
        if (w_hit) begin
          w_state_nx = S_DEAD;
          w_set_coll = 1'b1;
        end else if (bus.pause) begin
          w_state_nx = S_PAUSED;
        end else if (bus.tick) begin
          w_scroll = 1'b1;
        end
      end
      S_PAUSED: if (bus.pause) w_state_nx = S_RUN;
      S_DEAD:   if (bus.start) begin w_state_nx = S_IDLE; w_clr_coll = 1'b1; end
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_score     <= '0;
      r_collision <= 1'b0;
      r_lfsr      <= c_lfsr_seed;
    end else begin
      r_state <= w_state_nx;
      // Fibonacci taps 16,14,13,11, shifting toward bit 0.
      r_lfsr  <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
      if (w_set_coll)      r_collision <= 1'b1;
      else if (w_clr_coll) r_collision <= 1'b0;
      if (w_reload)        r_score <= '0;
      else if (w_scroll)   r_score <= w_score_sum[32] ? '1 : w_score_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_pipe_x[i] <= 32'(SCREEN_W + i * PIPE_SEP);
        r_pipe_y[i] <= c_y_reset;
      end
    end else if (w_reload) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_pipe_x[i] <= 32'(SCREEN_W + i * PIPE_SEP);
        r_pipe_y[i] <= c_y_reset;
      end
    end else if (w_scroll) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_pipe_x[i] <= w_x_nx[i];
        if (w_wrap[i]) r_pipe_y[i] <= w_y_spawn;
      end
    end
  end

`ifdef DIFFICULTY_RAMP_EN
  localparam logic [2:0] c_speed_max = 3'(MAX_SPEED);
  logic [31:0] r_ramp_cnt;
  logic [31:0] r_scored_last;

  // Pipes scored on a tick are folded into the ramp one cycle later, so a new
  // speed shows up the cycle after the score that earned it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed       <= 3'd1;
      r_ramp_cnt    <= '0;
      r_scored_last <= '0;
    end else if (w_reload) begin
      r_speed       <= 3'd1;
      r_ramp_cnt    <= '0;
      r_scored_last <= '0;
    end else begin
      r_scored_last <= w_scroll ? w_cross_cnt : '0;
      if (r_scored_last != '0) begin
        if (r_ramp_cnt + r_scored_last >= 32'(RAMP_STEP)) begin
          r_ramp_cnt <= '0;
          if (r_speed < c_speed_max) r_speed <= r_speed + 3'd1;
        end else begin
          r_ramp_cnt <= r_ramp_cnt + r_scored_last;
        end
      end
    end
  end
`else
  assign r_speed = 3'd1;
  // Ramp settings only take effect when the ramp is built in.
  if (RAMP_STEP < 1 || MAX_SPEED < 1) begin : g_ramp_cfg_unused
  end
`endif

  assign bus.score_count = r_score;
  assign bus.speed       = r_speed;
  assign bus.collision   = r_collision;
  assign bus.game_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_engine
// Description : Self-checking bench for pipe_engine. Directed scenarios from
//               the game rules plus a long randomized run compared against a
//               behavioural model of the rules kept in this file.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_engine;
  localparam int NP = 4;
  localparam longint L_SEP = 250, L_W = 78, L_GAP = 75, L_SCR = 640;
  localparam longint L_FLOOR = 400, L_YMIN = 60, L_BX = 150, L_BSX = 54, L_BSY = 45;
  localparam int L_RAMP = 1, L_MAXSPD = 4;
  localparam longint L_SAT = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  pipe_engine_if #(.NUM_PIPES(NP)) bus();
  pipe_engine #(.NUM_PIPES(NP), .RAMP_STEP(L_RAMP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model of the game rules ----------------
  int         m_state;
  longint     m_x [NP];
  longint     m_y [NP];
  longint     m_score;
  int         m_speed, m_ramp, m_pend;
  bit         m_coll;
  bit [15:0]  m_lfsr;

  function automatic void model_reload();
    for (int i = 0; i < NP; i++) begin
      m_x[i] = L_SCR + i * L_SEP;
      m_y[i] = L_YMIN + 63;
    end
    m_speed = 1; m_ramp = 0; m_pend = 0; m_score = 0;
  endfunction

  function automatic void model_reset();
    model_reload();
    m_state = 0; m_coll = 0; m_lfsr = 16'hACE1;
  endfunction

  function automatic void model_step(bit tk, bit st, bit ps, longint by);
    bit hit = 0, reload = 0;
    longint bot = by + L_BSY, nx;
    int scored = 0, pend_now;
    if (m_state == 1) begin
      if (bot > L_FLOOR) hit = 1;
      for (int i = 0; i < NP; i++)
        if (m_x[i] < L_BX + L_BSX && m_x[i] + L_W > L_BX &&
            (by < m_y[i] || bot > m_y[i] + L_GAP)) hit = 1;
    end
    pend_now = m_pend;
    case (m_state)
      0: if (st) begin m_state = 1; reload = 1; model_reload(); end
      1: if (hit) begin m_state = 3; m_coll = 1; end
         else if (ps) m_state = 2;
         else if (tk) begin
           for (int i = 0; i < NP; i++) begin
             nx = m_x[i] - m_speed;
             if (m_x[i] + L_W >= L_BX && nx + L_W < L_BX) scored++;
             if (nx <= -L_W) begin
               nx = nx + NP * L_SEP;
               m_y[i] = L_YMIN + longint'(m_lfsr & 16'd127);
             end
             m_x[i] = nx;
           end
           m_score = m_score + scored;
           if (m_score > L_SAT) m_score = L_SAT;
         end
      2: if (ps) m_state = 1;
      default: if (st) begin m_state = 0; m_coll = 0; end
    endcase
`ifdef DIFFICULTY_RAMP_EN
    if (!reload) begin
      if (pend_now > 0) begin
        m_ramp = m_ramp + pend_now;
        if (m_ramp >= L_RAMP) begin
          m_ramp = 0;
          if (m_speed < L_MAXSPD) m_speed++;
        end
      end
      m_pend = scored;
    end
`else
    m_pend = pend_now;
`endif
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endfunction

  // One clock of stimulus: drive at a falling edge, return at the next one.
  task automatic cyc(input bit tk, input bit st, input bit ps);
    bus.tick = tk; bus.start = st; bus.pause = ps;
    model_step(tk, st, ps, longint'(bus.birdY));
    @(negedge clk);
    bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic longint px(int i);
    return longint'($signed(bus.pipeX_flat[32*i +: 32]));
  endfunction

  function automatic longint py(int i);
    return longint'(bus.pipeY_flat[32*i +: 32]);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (bus.game_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.game_state); end
    n_checks++; if (bus.score_count !== 32'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", bus.score_count); end
    n_checks++; if (bus.speed !== 3'd1) begin n_fail++; $display("FAIL reset_speed: got %0d expected 1", bus.speed); end
    n_checks++; if (bus.collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision: got %0d expected 0", bus.collision); end
    for (int i = 0; i < NP; i++) begin
      n_checks++; if (px(i) !== L_SCR + i * L_SEP) begin n_fail++; $display("FAIL reset_x%0d: got %0d expected %0d", i, px(i), L_SCR + i * L_SEP); end
      n_checks++; if (py(i) !== 64'd123) begin n_fail++; $display("FAIL reset_y%0d: got %0d expected 123", i, py(i)); end
    end
  endtask

  task automatic test_start();
    bus.birdY = 32'd130;
    cyc(0, 0, 1);
    n_checks++; if (bus.game_state !== 2'd0) begin n_fail++; $display("FAIL idle_pause_ignored: got %0d expected 0", bus.game_state); end
    cyc(0, 1, 0);
    n_checks++; if (bus.game_state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d expected 1", bus.game_state); end
    n_checks++; if (bus.score_count !== 32'd0) begin n_fail++; $display("FAIL start_score: got %0d expected 0", bus.score_count); end
    for (int i = 0; i < NP; i++) begin
      n_checks++; if (px(i) !== L_SCR + i * L_SEP) begin n_fail++; $display("FAIL start_x%0d: got %0d expected %0d", i, px(i), L_SCR + i * L_SEP); end
      n_checks++; if (py(i) !== 64'd123) begin n_fail++; $display("FAIL start_y%0d: got %0d expected 123", i, py(i)); end
    end
    cyc(0, 1, 0);
    n_checks++; if (bus.game_state !== 2'd1) begin n_fail++; $display("FAIL run_start_ignored: got %0d expected 1", bus.game_state); end
  endtask

  task automatic test_score_and_recycle();
    int bad_coll = 0;
    for (int t = 1; t <= 568; t++) begin
      cyc(1, 0, 0);
      if (bus.collision !== 1'b0) bad_coll++;
    end
    n_checks++; if (bus.score_count !== 32'd0) begin n_fail++; $display("FAIL score_at_568: got %0d expected 0", bus.score_count); end
    n_checks++; if (px(0) !== 64'd72) begin n_fail++; $display("FAIL x0_at_568: got %0d expected 72", px(0)); end
    cyc(1, 0, 0);
    n_checks++; if (bus.score_count !== 32'd1) begin n_fail++; $display("FAIL score_at_569: got %0d expected 1", bus.score_count); end
    n_checks++; if (px(0) !== 64'd71) begin n_fail++; $display("FAIL x0_at_569: got %0d expected 71", px(0)); end
    cyc(0, 0, 0);
`ifdef DIFFICULTY_RAMP_EN
    n_checks++; if (bus.speed !== 3'd2) begin n_fail++; $display("FAIL ramp_speed: got %0d expected 2", bus.speed); end
    cyc(1, 0, 0);
    n_checks++; if (px(0) !== 64'd69) begin n_fail++; $display("FAIL ramp_step_x0: got %0d expected 69", px(0)); end
`else
    n_checks++; if (bus.speed !== 3'd1) begin n_fail++; $display("FAIL const_speed: got %0d expected 1", bus.speed); end
    for (int t = 570; t <= 718; t++) begin
      cyc(1, 0, 0);
      if (bus.collision !== 1'b0) bad_coll++;
    end
    n_checks++; if (px(0) !== 64'd922) begin n_fail++; $display("FAIL recycle_x0: got %0d expected 922", px(0)); end
    n_checks++; if (py(0) < 64'd60 || py(0) > 64'd187 || py(0) !== m_y[0]) begin n_fail++; $display("FAIL recycle_y0: got %0d expected %0d", py(0), m_y[0]); end
    n_checks++; if (px(1) !== 64'd172 || px(2) !== 64'd422 || px(3) !== 64'd672) begin n_fail++; $display("FAIL recycle_others: got %0d %0d %0d expected 172 422 672", px(1), px(2), px(3)); end
`endif
    n_checks++; if (bad_coll != 0) begin n_fail++; $display("FAIL score_no_collision: got %0d cycles with collision expected 0", bad_coll); end
  endtask

  task automatic test_pause();
    apply_reset();
    bus.birdY = 32'd130;
    cyc(0, 1, 0);
    cyc(1, 0, 1);
    n_checks++; if (bus.game_state !== 2'd2 || px(0) !== 64'd640) begin n_fail++; $display("FAIL pause_with_tick: got state %0d x0 %0d expected 2 640", bus.game_state, px(0)); end
    for (int t = 0; t < 10; t++) begin
      cyc(1, 0, 0);
      n_checks++; if (bus.game_state !== 2'd2 || px(0) !== 64'd640) begin n_fail++; $display("FAIL paused_frozen: got state %0d x0 %0d expected 2 640", bus.game_state, px(0)); end
    end
    cyc(0, 0, 1);
    n_checks++; if (bus.game_state !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d expected 1", bus.game_state); end
    cyc(1, 0, 0);
    n_checks++; if (px(0) !== 64'd639) begin n_fail++; $display("FAIL resume_x0: got %0d expected 639", px(0)); end
  endtask

  task automatic test_hit();
    apply_reset();
    bus.birdY = 32'd0;
    cyc(0, 1, 0);
    for (int t = 1; t <= 437; t++) cyc(1, 0, 0);
    n_checks++; if (px(0) !== 64'd203 || bus.collision !== 1'b0) begin n_fail++; $display("FAIL hit_approach: got x0 %0d coll %0d expected 203 0", px(0), bus.collision); end
    cyc(1, 0, 1);
    n_checks++; if (bus.game_state !== 2'd3 || bus.collision !== 1'b1) begin n_fail++; $display("FAIL hit_dead: got state %0d coll %0d expected 3 1", bus.game_state, bus.collision); end
    n_checks++; if (px(0) !== 64'd203) begin n_fail++; $display("FAIL hit_tick_dropped: got %0d expected 203", px(0)); end
    for (int t = 0; t < 5; t++) cyc(1, 0, 1);
    n_checks++; if (px(0) !== 64'd203 || bus.game_state !== 2'd3) begin n_fail++; $display("FAIL dead_frozen: got x0 %0d state %0d expected 203 3", px(0), bus.game_state); end
    cyc(0, 1, 0);
    n_checks++; if (bus.game_state !== 2'd0 || bus.collision !== 1'b0) begin n_fail++; $display("FAIL dead_restart: got state %0d coll %0d expected 0 0", bus.game_state, bus.collision); end
  endtask

  task automatic test_floor();
    apply_reset();
    bus.birdY = 32'd355;
    cyc(0, 1, 0);
    for (int t = 0; t < 3; t++) cyc(1, 0, 0);
    n_checks++; if (bus.game_state !== 2'd1 || bus.collision !== 1'b0) begin n_fail++; $display("FAIL floor_edge_safe: got state %0d coll %0d expected 1 0", bus.game_state, bus.collision); end
    bus.birdY = 32'd356;
    cyc(0, 0, 0);
    n_checks++; if (bus.game_state !== 2'd3 || bus.collision !== 1'b1) begin n_fail++; $display("FAIL floor_hit: got state %0d coll %0d expected 3 1", bus.game_state, bus.collision); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.birdY = 32'd130;
    cyc(0, 1, 0);
    for (int t = 0; t < 3; t++) cyc(1, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (px(0) !== 64'd640 || bus.game_state !== 2'd0) begin n_fail++; $display("FAIL async_reset: got x0 %0d state %0d expected 640 0", px(0), bus.game_state); end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (px(0) !== 64'd640 || bus.speed !== 3'd1) begin n_fail++; $display("FAIL reset_held: got x0 %0d speed %0d expected 640 1", px(0), bus.speed); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit tk, st, ps;
    apply_reset();
    bus.birdY = 32'd130;
    for (int c = 0; c < 20000; c++) begin
      if (c % 64 == 0)
        bus.birdY = ($urandom_range(0, 9) < 8) ? 32'd130 : 32'($urandom_range(0, 420));
      tk = ($urandom_range(0, 1) == 1);
      st = (m_state == 0 || m_state == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 39) == 0);
      ps = ($urandom_range(0, 59) == 0);
      cyc(tk, st, ps);
      n_checks++; if (int'(bus.game_state) !== m_state) begin n_fail++; $display("FAIL rand_state c%0d: got %0d expected %0d", c, bus.game_state, m_state); end
      n_checks++; if (longint'(bus.score_count) !== m_score) begin n_fail++; $display("FAIL rand_score c%0d: got %0d expected %0d", c, bus.score_count, m_score); end
      n_checks++; if (int'(bus.speed) !== m_speed) begin n_fail++; $display("FAIL rand_speed c%0d: got %0d expected %0d", c, bus.speed, m_speed); end
      n_checks++; if (bus.collision !== m_coll) begin n_fail++; $display("FAIL rand_coll c%0d: got %0d expected %0d", c, bus.collision, m_coll); end
      for (int i = 0; i < NP; i++) begin
        n_checks++; if (px(i) !== m_x[i] || py(i) !== m_y[i]) begin n_fail++; $display("FAIL rand_pipe%0d c%0d: got %0d,%0d expected %0d,%0d", i, c, px(i), py(i), m_x[i], m_y[i]); end
      end
      if (n_fail > 50) break;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.birdY = 32'd130;
    test_reset();
    test_start();
    test_score_and_recycle();
    test_pause();
    test_hit();
    test_floor();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_engine.md
# pipe_engine

Parametrised obstacle and game-flow engine that supersedes the fixed four-pipe controller, the separate collision detector and the game FSM in the flappy_bird top level. It keeps NUM_PIPES pipes in a recycling ring, draws fresh gap heights from an LFSR, counts score and optionally speeds up with score. It detects bird/pipe/floor overlap and runs the IDLE/RUN/PAUSED/DEAD state machine. The image renderer and score display consume its flattened pipe buses.

## Interface
- NUM_PIPES, 4, pipes in ring (≥2)
- PIPE_SEP, 250, horizontal spacing (px); NUM_PIPES*PIPE_SEP ≥ SCREEN_W+PIPE_W required
- PIPE_W, 78, pipe width (px)
- PIPE_GAP, 75, vertical gap height (px)
- SCREEN_W, 640, spawn X of pipe 0
- FLOOR_Y, 400, floor line; bird bottom beyond it is a collision
- Y_MIN, 60, minimum gap top
- Y_MASK, 127, gap top = Y_MIN + (lfsr & Y_MASK)
- BIRD_X / BIRD_SIZE_X / BIRD_SIZE_Y, 150 / 54 / 45, bird box
- RAMP_STEP, 10, points per speed level (ramp builds only)
- MAX_SPEED, 4, speed ceiling in px/tick
- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle scroll strobe (floor-rate divider)
- start  in  1  one-cycle pulse
- pause  in  1  one-cycle toggle pulse
- birdY  in  32  bird top Y (unsigned)
- pipeX_flat  out  32*NUM_PIPES  signed X of pipe i in bits [32i+31:32i]
- pipeY_flat  out  32*NUM_PIPES  gap top of pipe i
- score_count  out  32  pipes passed
- speed  out  3  current px/tick
- collision  out  1  overlap latched
- game_state  out  2  0 IDLE, 1 RUN, 2 PAUSED, 3 DEAD

## Operation
- Reset values:
  - game_state=0, score_count=0, speed=1, collision=0.
  - pipe i X=SCREEN_W+i*PIPE_SEP, Y=Y_MIN+(Y_MASK>>1).
  - LFSR=16'hACE1.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk in all states.
- FSM transitions:
  - IDLE –start→ RUN. Pipes and speed are reloaded to their reset values and score is cleared.
  - RUN –pause→ PAUSED, and PAUSED –pause→ RUN.
  - RUN –hit→ DEAD.
  - DEAD –start→ IDLE, which clears collision.
  - start in RUN/PAUSED and pause in IDLE/DEAD are ignored.
- Scrolling:
  - Only on tick while in RUN; every X decreases by speed.
  - If the new X ≤ −PIPE_W, that pipe is instead written with X+NUM_PIPES*PIPE_SEP and Y=Y_MIN+(lfsr&Y_MASK).
  - Several pipes may recycle on the same tick; each recycling pipe samples the same LFSR value.
- Scoring:
  - A pipe scores when its right edge (X+PIPE_W) goes from ≥BIRD_X to <BIRD_X on a tick.
  - Simultaneous crossings add their count in one cycle.
  - score_count saturates at 2^32−1.
- Hit (combinational, RUN only), true if either condition holds:
  - birdY+BIRD_SIZE_Y > FLOOR_Y.
  - For any pipe i, X-ranges [BIRD_X, BIRD_X+BIRD_SIZE_X) and [X_i, X_i+PIPE_W) overlap, and (birdY < Y_i or birdY+BIRD_SIZE_Y > Y_i+PIPE_GAP).
- All comparisons are 33-bit signed.

## Timing
- All outputs are registered.
- tick at cycle n → new X/Y/score/speed visible at n+1.
- Hit true at cycle n:
  - collision=1 and game_state=3 at n+1.
  - A tick in that same cycle is discarded; positions freeze.
- Simultaneous events:
  - Hit and pause in the same cycle → DEAD (hit wins).
  - pause and tick in the same cycle while in RUN → PAUSED, tick discarded.
- Reset asserted mid-game forces all reset values immediately (asynchronous) and holds them until release.

## Configuration
- DIFFICULTY_RAMP_EN defined:
  - A ramp counter increments per scored pipe.
  - On reaching RAMP_STEP it clears and speed increments, up to MAX_SPEED.
  - The new speed applies from the next tick.
- Undefined: speed is constant 1 and RAMP_STEP/MAX_SPEED are unused.

## Test plan
- Reset, start, no ticks → pipeX = 640, 890, 1140, 1390; pipeY all 123; game_state=1; score=0.
- birdY=130, 569 ticks → pipe0 X=71, score_count=1 at tick 569 (0 at tick 568), collision=0 throughout.
- birdY=130, 718 ticks → pipe0 X=922, pipe0 Y in [60,187]; pipes 1–3 X = 172, 422, 672.
- pause, 10 ticks, pause, 1 tick → X frozen while game_state=2; after resume, pipe0 X=639.
- birdY=0, 437 ticks → pipe0 X=203, collision=1, game_state=3; 5 more ticks leave X=203; start → game_state=0, collision=0.
- DIFFICULTY_RAMP_EN, RAMP_STEP=1, birdY=130 → speed=2 one cycle after score reaches 1; next tick moves pipe0 by 2. Without the macro, speed stays 1.
